// File: rtl/msi_pkg.sv
// rtl/msi_pkg.sv - MSI state encodings and write-back FSM states
package msi_pkg;

  typedef logic [1:0] msi_state_t;

  localparam msi_state_t MSI_INVALID  = 2'b00;
  localparam msi_state_t MSI_MODIFIED = 2'b01;
  localparam msi_state_t MSI_SHARED   = 2'b10;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_READ,
    WB_WRITE,
    WB_COMMIT
  } wb_state_t;

endpackage

// File: rtl/msi_wb_word_sequencer.sv
// rtl/msi_wb_word_sequencer.sv - word index, read/write alternation and last flag
module msi_wb_word_sequencer
  import msi_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  wb_state_t         state,
  input  logic              mem_wr_ready,
  input  logic [DATA_W-1:0] line_rd_data,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_last,
  output wb_state_t         burst_next
);

  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic              first_q;
  logic              last_word;

  assign last_word = (idx_q == IDX_W'(BLOCK_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
    end else begin
      first_q <= (state == WB_READ);
      if (first_q) data_q <= line_rd_data;
      if (state == WB_COMMIT) idx_q <= '0;
      else if (state == WB_WRITE && mem_wr_ready && !last_word) idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Read data arrives on the first WRITE cycle; present it directly, then hold the copy.
  assign wr_data = first_q ? line_rd_data : data_q;
  assign wr_last = (state == WB_WRITE) && last_word;
  assign idx     = idx_q;

  always_comb begin
    burst_next = state;
    case (state)
      WB_READ:  burst_next = WB_WRITE;
      WB_WRITE: if (mem_wr_ready) burst_next = last_word ? WB_COMMIT : WB_READ;
      default:  burst_next = state;
    endcase
  end

endmodule

// File: rtl/msi_snoop_writeback_unit.sv
// rtl/msi_snoop_writeback_unit.sv - snoop write-back sequencer and MSI state commit
// Optional stall timeout enabled by MSI_WB_TIMEOUT_EN.
module msi_snoop_writeback_unit
  import msi_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int BLOCK_WORDS    = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDX_W         = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snoop_valid,
  output logic              snoop_ready,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  msi_state_t        state_next,
  input  logic              write_back_block,
  input  logic              abort_mem_access,
  output logic              line_rd_en,
  output logic [IDX_W-1:0]  line_rd_word,
  input  logic [DATA_W-1:0] line_rd_data,
  output logic              mem_abort,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_last,
  output logic              state_wr_en,
  output logic [ADDR_W-1:0] state_wr_addr,
  output msi_state_t        state_wr_val,
  output logic              wb_done
`ifdef MSI_WB_TIMEOUT_EN
  ,
  output logic              wb_timeout
`endif
);

  wb_state_t         state_q, burst_next;
  logic [ADDR_W-1:0] base_q;
  msi_state_t        st_q;
  logic              snoop_ready_q, line_rd_en_q, mem_abort_q, mem_wr_valid_q;
  logic              state_wr_en_q, wb_done_q, timeout_hit;
  logic [IDX_W-1:0]  idx;

  msi_wb_word_sequencer #(
    .DATA_W      (DATA_W),
    .BLOCK_WORDS (BLOCK_WORDS),
    .IDX_W       (IDX_W)
  ) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .state        (state_q),
    .mem_wr_ready (mem_wr_ready),
    .line_rd_data (line_rd_data),
    .idx          (idx),
    .wr_data      (mem_wr_data),
    .wr_last      (mem_wr_last),
    .burst_next   (burst_next)
  );

`ifdef MSI_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_q;
  logic             timeout_q;

  assign timeout_hit = (state_q == WB_WRITE) && !mem_wr_ready &&
                       (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign wb_timeout  = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == WB_WRITE && !mem_wr_ready && !timeout_hit) stall_q <= stall_q + CNT_W'(1);
      else stall_q <= '0;
      if (state_q == WB_IDLE && snoop_valid) timeout_q <= 1'b0;
      else if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= WB_IDLE;
      base_q         <= '0;
      st_q           <= MSI_INVALID;
      snoop_ready_q  <= 1'b1;
      line_rd_en_q   <= 1'b0;
      mem_abort_q    <= 1'b0;
      mem_wr_valid_q <= 1'b0;
      state_wr_en_q  <= 1'b0;
      wb_done_q      <= 1'b0;
    end else begin
      line_rd_en_q  <= 1'b0;
      mem_abort_q   <= 1'b0;
      state_wr_en_q <= 1'b0;
      wb_done_q     <= 1'b0;
      case (state_q)
        WB_IDLE: if (snoop_valid) begin
          base_q        <= snoop_addr & ~ADDR_W'(BLOCK_WORDS - 1);
          st_q          <= state_next;
          mem_abort_q   <= abort_mem_access;
          snoop_ready_q <= 1'b0;
          if (write_back_block) begin
            state_q      <= WB_READ;
            line_rd_en_q <= 1'b1;
          end else begin
            state_q       <= WB_COMMIT;
            state_wr_en_q <= 1'b1;
          end
        end
        WB_READ, WB_WRITE: begin
          if (timeout_hit) begin
            state_q        <= WB_COMMIT;
            mem_wr_valid_q <= 1'b0;
            state_wr_en_q  <= 1'b1;
          end else begin
            state_q        <= burst_next;
            line_rd_en_q   <= (burst_next == WB_READ);
            mem_wr_valid_q <= (burst_next == WB_WRITE);
            state_wr_en_q  <= (burst_next == WB_COMMIT);
            wb_done_q      <= (burst_next == WB_COMMIT);
          end
        end
        WB_COMMIT: begin
          state_q       <= WB_IDLE;
          snoop_ready_q <= 1'b1;
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign snoop_ready   = snoop_ready_q;
  assign line_rd_en    = line_rd_en_q;
  assign line_rd_word  = idx;
  assign mem_abort     = mem_abort_q;
  assign mem_wr_valid  = mem_wr_valid_q;
  assign mem_wr_addr   = base_q | ADDR_W'(idx);
  assign state_wr_en   = state_wr_en_q;
  assign state_wr_addr = base_q;
  assign state_wr_val  = st_q;
  assign wb_done       = wb_done_q;

endmodule
